// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe
// Streaming add/subtract stage built around a 32-bit two-level carry-lookahead
// adder. Operand beats are registered in S1, summed combinationally, and the
// result plus flags are registered in S2. Consecutive beats of one operation
// chain the carry, so wider add/sub runs through the single 32-bit adder.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready          operand handshake
//   in_x, in_y, in_sub         operand word, operation (sampled on chain start)
//   in_first, in_last          LS / MS word markers of a multi-word operation
//   out_valid/out_ready        result handshake
//   out_s, out_cout            result word and its carry out
//   out_ovf                    signed overflow (last word only)
//   out_zero                   all result words of the chain so far are zero
//   out_last                   in_last of this beat
//   out_proto_err              sticky: beat without in_first while no chain open
//
// Build option: define CLA_PIPE_SAT_EN to saturate single-word results that
// overflow (0x7FFF_FFFF / 0x8000_0000, sign from x[31]).

module cla_addsub_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_sub,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_s,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              out_zero,
    output logic              out_last,
    output logic              out_proto_err
);

    // The lookahead structure below is hard-wired to 32 bits.
    generate
        if (DATA_W != 32) begin : g_width_check
            $error("cla_addsub_pipe: DATA_W must be 32");
        end
    endgenerate

    // Two-level CLA: 4-bit groups produce group generate/propagate, group
    // carries are looked ahead from those, bit carries are resolved in-group.
    function automatic logic [32:0] cla32(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        cin);
        logic [31:0] g;
        logic [31:0] p;
        logic [7:0]  gg;
        logic [7:0]  gp;
        logic [8:0]  gc;
        logic [32:0] c;
        g  = a & b;
        p  = a ^ b;
        c  = 33'd0;
        gc = 9'd0;
        for (int j = 0; j < 8; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
        end
        gc[0] = cin;
        for (int j = 0; j < 8; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < 8; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[32] = gc[8];
        return {c[32], p ^ c[31:0]};
    endfunction

    logic        s1_valid_r;
    logic [31:0] s1_x_r;
    logic [31:0] s1_y_r;
    logic        s1_sub_r;
    logic        s1_first_r;
    logic        s1_last_r;

    logic        chain_open_r;
    logic        chain_carry_r;
    logic        chain_sub_r;
    logic        chain_zero_r;

    logic        s2_load_s;
    logic        in_fire_s;
    logic        restart_s;
    logic        eff_sub_s;
    logic [31:0] y_eff_s;
    logic        cin_s;
    logic [32:0] sum_s;
    logic        ovf_raw_s;
    logic [31:0] s_fin_s;
    logic        zero_next_s;

    assign s2_load_s = s1_valid_r & (~out_valid | out_ready);
    assign in_ready  = ~s1_valid_r | s2_load_s;
    assign in_fire_s = in_valid & in_ready;

    // Adder datapath: a beat restarts the chain if it is marked first or if
    // no chain is open; a restart takes its own operation and carry-in.
    always_comb begin
        restart_s   = s1_first_r | ~chain_open_r;
        eff_sub_s   = restart_s ? s1_sub_r : chain_sub_r;
        y_eff_s     = eff_sub_s ? ~s1_y_r : s1_y_r;
        cin_s       = restart_s ? eff_sub_s : chain_carry_r;
        sum_s       = cla32(s1_x_r, y_eff_s, cin_s);
        // carry into bit 31 xor carry out of bit 31
        ovf_raw_s   = s1_x_r[31] ^ y_eff_s[31] ^ sum_s[31] ^ sum_s[32];
        s_fin_s     = sum_s[31:0];
`ifdef CLA_PIPE_SAT_EN
        if (s1_first_r & s1_last_r & ovf_raw_s) begin
            s_fin_s = s1_x_r[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            s_fin_s = sum_s[31:0];
        end
`endif
        zero_next_s = (restart_s ? 1'b1 : chain_zero_r) & (s_fin_s == 32'd0);
    end

    // S1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= 32'd0;
            s1_y_r     <= 32'd0;
            s1_sub_r   <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_x_r     <= in_x;
            s1_y_r     <= in_y;
            s1_sub_r   <= in_sub;
            s1_first_r <= in_first;
            s1_last_r  <= in_last;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Chain state, protocol error flag and S2 result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_open_r  <= 1'b0;
            chain_carry_r <= 1'b0;
            chain_sub_r   <= 1'b0;
            chain_zero_r  <= 1'b1;
            out_proto_err <= 1'b0;
            out_valid     <= 1'b0;
            out_s         <= 32'd0;
            out_cout      <= 1'b0;
            out_ovf       <= 1'b0;
            out_zero      <= 1'b0;
            out_last      <= 1'b0;
        end else if (s2_load_s) begin
            chain_open_r  <= ~s1_last_r;
            chain_carry_r <= sum_s[32];
            chain_sub_r   <= eff_sub_s;
            chain_zero_r  <= zero_next_s;
            if (~s1_first_r & ~chain_open_r) begin
                out_proto_err <= 1'b1;
            end
            out_valid     <= 1'b1;
            out_s         <= s_fin_s;
            out_cout      <= sum_s[32];
            out_ovf       <= s1_last_r & ovf_raw_s;
            out_zero      <= zero_next_s;
            out_last      <= s1_last_r;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
`timescale 1ns/1ps
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = 32'd0;
    logic [31:0] in_y = 32'd0;
    logic        in_sub = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_s;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic        out_last;
    logic        out_proto_err;

    cla_addsub_pipe #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_sub(in_sub),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_last(out_last),
        .out_proto_err(out_proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        last;
        logic        proto;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
        logic        first;
        logic        last;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;
    bit   saw_not_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: whole-operation arithmetic on accumulated wide operands.
    logic         m_open = 1'b0;
    logic         m_sub = 1'b0;
    logic         m_proto = 1'b0;
    int           m_k = 0;
    logic [128:0] m_x = '0;
    logic [128:0] m_y = '0;

    task automatic model_reset();
        m_open = 1'b0; m_sub = 1'b0; m_proto = 1'b0; m_k = 0; m_x = '0; m_y = '0;
    endtask

    task automatic model_beat(input logic [31:0] x, input logic [31:0] y, input logic sub,
                              input logic first, input logic last, output exp_t e);
        logic [128:0] mask;
        logic [128:0] res;
        int           w;
        logic         sx, sy, sr;
        if (!first && !m_open) m_proto = 1'b1;
        if (first || !m_open) begin
            m_k = 0; m_x = '0; m_y = '0; m_sub = sub;
        end else begin
            m_k++;
        end
        m_x  = m_x | ({97'd0, x} << (32 * m_k));
        m_y  = m_y | ({97'd0, y} << (32 * m_k));
        w    = 32 * (m_k + 1);
        mask = (129'd1 << w) - 129'd1;
        if (!m_sub) begin
            res    = m_x + m_y;
            e.cout = res[w];
        end else begin
            res    = (m_x - m_y) & mask;
            e.cout = (m_x >= m_y);
        end
        e.s   = res[32*m_k +: 32];
        sx    = m_x[w-1];
        sy    = m_y[w-1];
        sr    = res[w-1];
        e.ovf = last && (m_sub ? (sx != sy && sr != sx) : (sx == sy && sr != sx));
        e.zero = ((res & mask) == 129'd0);
`ifdef CLA_PIPE_SAT_EN
        if (first && last && e.ovf) begin
            e.s    = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.zero = 1'b0;
        end
`endif
        e.last  = last;
        e.proto = m_proto;
        m_open  = !last;
    endtask

    // Output monitor: in-order scoreboard plus stall stability.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_s = 32'd0;
    logic [3:0]  prev_flags = 4'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (in_valid && !in_ready) saw_not_ready = 1'b1;
            if (stall_prev) begin
                chk("stall_stable_s", out_s, prev_s);
                chk("stall_stable_flags", {28'd0, out_cout, out_ovf, out_zero, out_last}, {28'd0, prev_flags});
                chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", out_s);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_s", out_s, e.s);
                    chk("out_cout", {31'd0, out_cout}, {31'd0, e.cout});
                    chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
                    chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    chk("out_proto_err", {31'd0, out_proto_err}, {31'd0, e.proto});
                    out_count++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_s     = out_s;
            prev_flags = {out_cout, out_ovf, out_zero, out_last};
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic sub,
                        input logic first, input logic last, output bit ok);
        bit acc;
        in_x = x; in_y = y; in_sub = sub; in_first = first; in_last = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic beat_model(input logic [31:0] x, input logic [31:0] y, input logic sub,
                              input logic first, input logic last);
        bit   ok;
        exp_t e;
        send(x, y, sub, first, last, ok);
        if (ok) begin
            model_beat(x, y, sub, first, last, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t tbl[10];
    bit   rand_done;

    initial begin
        bit       ok;
        exp_t     e;
        int       base;
        logic [3:0] pat;

        // Vectors: {x, y, sub, first, last, s, cout, ovf, zero}
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
`ifdef CLA_PIPE_SAT_EN
        tbl[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
`else
        tbl[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
`endif
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h9ABC_DEF0, 32'h9ABC_DEF0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_s", out_s, 32'd0);
        chk("rst_flags", {28'd0, out_cout, out_ovf, out_zero, out_last}, 32'd0);
        chk("rst_proto_err", {31'd0, out_proto_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Latency: accepted at one edge, out_valid visible after the next one
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b1, ok);
        if (ok) begin
            model_beat(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b1, e);
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("latency_cycle1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_cycle2_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Directed table, back to back
        foreach (tbl[i]) begin
            send(tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].first, tbl[i].last, ok);
            if (ok) begin
                model_beat(tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].first, tbl[i].last, e);
                e.s = tbl[i].s; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
                e.zero = tbl[i].zero; e.last = tbl[i].last; e.proto = 1'b0;
                exp_q.push_back(e);
            end
        end
        drain();

        // Backpressure: out_ready cycles 1,0,0,1
        base = out_count;
        saw_not_ready = 1'b0;
        pat = 4'b1001;
        fork
            begin
                for (int i = 0; i < 8; i++) beat_model($urandom, $urandom, 1'($urandom % 2), 1'b1, 1'b1);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk); #1;
                    out_ready = pat[c % 4];
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_deasserted", {31'd0, saw_not_ready}, 32'd1);
        chk("bp_beat_count", out_count - base, 32'd8);

        // Protocol error: beat without in_first while idle
        beat_model(32'h0000_0010, 32'h0000_0004, 1'b1, 1'b0, 1'b1);
        drain();
        chk("proto_sticky", {31'd0, out_proto_err}, 32'd1);

        // Reset mid-chain, with the first word sitting in S2
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0, ok);
        @(posedge clk); #2;
        chk("midchain_valid_before_rst", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_proto_err", {31'd0, out_proto_err}, 32'd0);
        chk("async_rst_out_s", out_s, 32'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat_model(32'h0000_0007, 32'h0000_0009, 1'b1, 1'b1, 1'b1);
        drain();

        // Randomized chains with random backpressure
        rand_done = 1'b0;
        fork
            begin
                bit force_first;
                force_first = 1'b0;
                for (int n = 0; n < 70; n++) begin
                    int   words, nsend;
                    logic sub, proto;
                    bit   abandon;
                    words   = $urandom_range(1, 4);
                    sub     = 1'($urandom % 2);
                    abandon = (words > 1) && ($urandom % 8 == 0);
                    proto   = !force_first && ($urandom % 10 == 0);
                    nsend   = abandon ? $urandom_range(1, words - 1) : words;
                    for (int w = 0; w < nsend; w++) begin
                        logic [31:0] x, y;
                        x = pick();
                        y = ($urandom % 4 == 0) ? x : pick();
                        beat_model(x, y, sub, (w == 0) && !proto, w == words - 1);
                    end
                    force_first = abandon;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom % 4 != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
